// File: rtl/conversor_sp_param.sv
// ============================================================================
// Module      : conversor_sp_param
// Description : Parametrised serial-to-parallel converter with a registered
//               word output, valid/read handshake and sticky overrun flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module conversor_sp_param #(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     pr,
  input  logic                     en,
  input  logic                     d,
  input  logic                     rd,
  output logic [WIDTH-1:0]         q,
  output logic [$clog2(WIDTH)-1:0] bit_cnt,
  output logic [WIDTH-1:0]         data_out,
  output logic                     valid,
  output logic                     overrun
);

  localparam int             c_cnt_w = $clog2(WIDTH);
  localparam [c_cnt_w-1:0]   c_last  = c_cnt_w'(WIDTH - 1);

  logic [WIDTH-1:0]   r_q;
  logic [c_cnt_w-1:0] r_cnt;
  logic [WIDTH-1:0]   r_data;
  logic               r_valid;
  logic               r_overrun;

  logic [WIDTH-1:0]   w_shift;
  logic               w_accept;
  logic               w_complete;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_shift = {r_q[WIDTH-2:0], d};
    end else begin : g_lsb_first
      assign w_shift = {d, r_q[WIDTH-1:1]};
    end
  endgenerate

  // pr suppresses the bit strobe, so a preset edge can never complete a word
  assign w_accept   = en & ~pr;
  assign w_complete = w_accept & (r_cnt == c_last);

  always_ff @(posedge clk) begin
    if (clr) begin
      r_q       <= '0;
      r_cnt     <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else begin
      if (pr) begin
        r_q   <= '1;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_q   <= w_shift;
        r_cnt <= w_complete ? '0 : r_cnt + 1'b1;
      end

      if (w_complete) begin
        r_data <= w_shift;
      end

      // A completion wins over a read on the same edge; the reader consumed
      // the old word, so only an unread overwrite raises overrun.
      if (w_complete) begin
        r_valid <= 1'b1;
      end else if (rd) begin
        r_valid <= 1'b0;
      end

      if (w_complete && r_valid && !rd) begin
        r_overrun <= 1'b1;
      end
    end
  end

  assign q        = r_q;
  assign bit_cnt  = r_cnt;
  assign data_out = r_data;
  assign valid    = r_valid;
  assign overrun  = r_overrun;

endmodule

`default_nettype wire

// File: tb/tb_conversor_sp_param.sv
// ============================================================================
// Module      : tb_conversor_sp_param
// Description : Directed self-checking bench for conversor_sp_param, covering
//               both bit orders with two instances sharing one input stream.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conversor_sp_param;

  logic       clk;
  logic       clr, pr, en, d, rd;
  logic [3:0] q_m, q_l, data_m, data_l;
  logic [1:0] cnt_m, cnt_l;
  logic       valid_m, valid_l, ovr_m, ovr_l;

  int checks = 0;
  int errors = 0;

  conversor_sp_param #(.WIDTH(4), .MSB_FIRST(1'b1)) dut_m (
    .clk(clk), .clr(clr), .pr(pr), .en(en), .d(d), .rd(rd),
    .q(q_m), .bit_cnt(cnt_m), .data_out(data_m), .valid(valid_m), .overrun(ovr_m)
  );

  conversor_sp_param #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_l (
    .clk(clk), .clr(clr), .pr(pr), .en(en), .d(d), .rd(rd),
    .q(q_l), .bit_cnt(cnt_l), .data_out(data_l), .valid(valid_l), .overrun(ovr_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge, outputs are sampled there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic rd_now);
    en = 1'b1; d = b; rd = rd_now;
    step();
    en = 1'b0; d = 1'b0; rd = 1'b0;
  endtask

  // Streams w[3] first; rd_last asserts rd alongside the final bit.
  task automatic send_word(input logic [3:0] w, input logic rd_last);
    for (int i = 3; i >= 0; i--) bit_in(w[i], (i == 0) ? rd_last : 1'b0);
  endtask

  task automatic do_clr();
    clr = 1'b1;
    step();
    clr = 1'b0;
  endtask

  initial begin
    clr = 1'b0; pr = 1'b0; en = 1'b0; d = 1'b0; rd = 1'b0;
    #2;

    // Reset state
    do_clr();
    chk("rst_q",       q_m,     4'h0);
    chk("rst_cnt",     cnt_m,   2'd0);
    chk("rst_data",    data_m,  4'h0);
    chk("rst_valid",   valid_m, 1'b0);
    chk("rst_overrun", ovr_m,   1'b0);

    // Stream 1,0,1,1 into both bit orders
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    chk("t1_cnt_mid",   cnt_m,   2'd2);
    chk("t1_valid_mid", valid_m, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    chk("t1_msb_data",  data_m,  4'b1011);
    chk("t1_msb_q",     q_m,     4'b1011);
    chk("t1_msb_cnt",   cnt_m,   2'd0);
    chk("t1_msb_valid", valid_m, 1'b1);
    chk("t2_lsb_data",  data_l,  4'b1101);
    chk("t2_lsb_valid", valid_l, 1'b1);

    // Read with no completion clears valid
    rd = 1'b1; step(); rd = 1'b0;
    chk("rd_clears_valid", valid_m, 1'b0);
    chk("rd_no_overrun",   ovr_m,   1'b0);

    // Gapped bits 1,1,0,0 with 3 idle cycles after each
    bit_in(1'b1, 1'b0);
    chk("t3_q_b0",   q_m,   4'b0111);
    chk("t3_cnt_b0", cnt_m, 2'd1);
    repeat (3) step();
    chk("t3_q_hold",   q_m,   4'b0111);
    chk("t3_cnt_hold", cnt_m, 2'd1);
    repeat (3) step();
    bit_in(1'b1, 1'b0); repeat (3) step();
    bit_in(1'b0, 1'b0); repeat (3) step();
    chk("t3_cnt_gap3", cnt_m,   2'd3);
    chk("t3_valid_pre", valid_m, 1'b0);
    bit_in(1'b0, 1'b0);
    chk("t3_data",  data_m,  4'b1100);
    chk("t3_valid", valid_m, 1'b1);

    // Back-to-back words without a read
    do_clr();
    send_word(4'b1010, 1'b0);
    chk("t4_first_data", data_m, 4'b1010);
    chk("t4_first_ovr",  ovr_m,  1'b0);
    send_word(4'b0101, 1'b0);
    chk("t4_ovr",   ovr_m,   1'b1);
    chk("t4_data",  data_m,  4'b0101);
    chk("t4_valid", valid_m, 1'b1);
    rd = 1'b1; step(); rd = 1'b0;
    chk("t4_ovr_sticky", ovr_m,   1'b1);
    chk("t4_valid_rd",   valid_m, 1'b0);

    // Same again with rd on the completion edge
    do_clr();
    send_word(4'b1010, 1'b0);
    send_word(4'b0110, 1'b1);
    chk("t4b_ovr",   ovr_m,   1'b0);
    chk("t4b_valid", valid_m, 1'b1);
    chk("t4b_data",  data_m,  4'b0110);

    // clr mid-frame discards the partial frame
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    do_clr();
    chk("t5_clr_q",     q_m,     4'h0);
    chk("t5_clr_cnt",   cnt_m,   2'd0);
    chk("t5_clr_data",  data_m,  4'h0);
    chk("t5_clr_valid", valid_m, 1'b0);
    chk("t5_clr_ovr",   ovr_m,   1'b0);
    send_word(4'b0110, 1'b0);
    chk("t5_data",  data_m,  4'b0110);
    chk("t5_valid", valid_m, 1'b1);

    // Preset overrides en, keeps the output word
    bit_in(1'b1, 1'b0);
    pr = 1'b1; en = 1'b1; d = 1'b0;
    step();
    pr = 1'b0; en = 1'b0;
    chk("t6_pr_q",     q_m,     4'b1111);
    chk("t6_pr_cnt",   cnt_m,   2'd0);
    chk("t6_pr_valid", valid_m, 1'b1);
    chk("t6_pr_data",  data_m,  4'b0110);

    // Preset still honours rd
    pr = 1'b1; rd = 1'b1;
    step();
    pr = 1'b0; rd = 1'b0;
    chk("t6_pr_rd_valid", valid_m, 1'b0);

    // Frame restarts cleanly after preset
    send_word(4'b0011, 1'b0);
    chk("t6_after_pr_data", data_m, 4'b0011);
    chk("t6_after_pr_lsb",  data_l, 4'b1100);

    // clr beats pr
    clr = 1'b1; pr = 1'b1;
    step();
    clr = 1'b0; pr = 1'b0;
    chk("t6_clr_pr_q", q_m, 4'h0);
    chk("t6_clr_pr_l", q_l, 4'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
